// File: rtl/controlador_carga_instrucoes_if.sv
// controlador_carga_instrucoes_if: byte-stream, memory-port and CPU-fetch signals of the instruction loader
interface controlador_carga_instrucoes_if #(parameter int ADDR_W = 8);
  logic iniciar_carga;
  logic [ADDR_W:0] num_palavras;
  logic executar;
  logic byte_valido;
  logic [7:0] byte_dado;
  logic byte_pronto;
  logic [31:0] pc;
  logic [31:0] instrucao_mem;
  logic [31:0] instrucao;
  logic [ADDR_W-1:0] mem_addr;
  logic mem_we;
  logic [31:0] mem_wdata;
  logic cpu_stall;
  logic carga_ativa;
  logic carga_concluida;
  logic erro_alinhamento;
  modport slave (
    input iniciar_carga, num_palavras, executar, byte_valido, byte_dado, pc, instrucao_mem,
    output byte_pronto, instrucao, mem_addr, mem_we, mem_wdata, cpu_stall, carga_ativa,
           carga_concluida, erro_alinhamento
  );
  modport master (
    output iniciar_carga, num_palavras, executar, byte_valido, byte_dado, pc, instrucao_mem,
    input byte_pronto, instrucao, mem_addr, mem_we, mem_wdata, cpu_stall, carga_ativa,
          carga_concluida, erro_alinhamento
  );
endinterface

// File: rtl/controlador_carga_instrucoes.sv
// controlador_carga_instrucoes: loads big-endian words from a byte stream into instruction memory, then hands the port to the CPU
module controlador_carga_instrucoes #(
  parameter int PALAVRAS = 256,
  parameter int ADDR_W = 8
) (
  input logic clk,
  input logic rst_n,
  controlador_carga_instrucoes_if.slave bus
);
  localparam logic [1:0] OCIOSO = 2'd0, CARGA = 2'd1, ESCRITA = 2'd2, EXECUCAO = 2'd3;
  logic [1:0] estado;
  logic [ADDR_W:0] total, contagem;
  logic [ADDR_W-1:0] endereco;
  logic [1:0] indice;
  logic [31:0] buffer;
  logic concluida, erro;
  logic executando, pedido_valido, aceita_byte, ultima;
  logic unused_pc;
  assign executando = estado == EXECUCAO;
  assign pedido_valido = bus.iniciar_carga && bus.num_palavras != '0 &&
                         bus.num_palavras <= (ADDR_W+1)'(PALAVRAS);
  assign aceita_byte = estado == CARGA && bus.byte_valido;
  assign ultima = (contagem + (ADDR_W+1)'(1)) == total;
  assign unused_pc = ^bus.pc[31:ADDR_W+2];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado <= OCIOSO;
      total <= '0;
      contagem <= '0;
      endereco <= '0;
      indice <= '0;
      buffer <= '0;
      concluida <= 1'b0;
      erro <= 1'b0;
    end else begin
      concluida <= 1'b0;
      if (executando && bus.pc[1:0] != 2'b00) erro <= 1'b1;
      // an accepted load overrides a same-cycle alignment error
      if ((estado == OCIOSO || executando) && pedido_valido) begin
        estado <= CARGA;
        total <= bus.num_palavras;
        contagem <= '0;
        endereco <= '0;
        indice <= '0;
        erro <= 1'b0;
      end else if (estado == OCIOSO && bus.executar) begin
        estado <= EXECUCAO;
      end else if (aceita_byte) begin
        buffer[5'd31 - {indice, 3'b000} -: 8] <= bus.byte_dado;
        indice <= indice + 2'd1;
        if (indice == 2'd3) estado <= ESCRITA;
      end else if (estado == ESCRITA) begin
        endereco <= endereco + ADDR_W'(1);
        contagem <= contagem + (ADDR_W+1)'(1);
        concluida <= ultima;
        estado <= ultima ? EXECUCAO : CARGA;
      end
    end
  end
  assign bus.byte_pronto = estado == CARGA;
  assign bus.mem_we = estado == ESCRITA;
  assign bus.mem_wdata = estado == ESCRITA ? buffer : 32'h0;
  assign bus.mem_addr = executando ? bus.pc[ADDR_W+1:2] : endereco;
  assign bus.instrucao = executando ? bus.instrucao_mem : 32'h0;
  assign bus.cpu_stall = !executando;
  assign bus.carga_ativa = estado == CARGA || estado == ESCRITA;
  assign bus.carga_concluida = concluida;
  assign bus.erro_alinhamento = erro;
endmodule
